pwm_deadtime: RTL

- Downstream consumer of the free-running `counter` output.
- Compares the counter value against a double-buffered duty value and drives a complementary high/low PWM pair with programmable dead time.
- Duty updates arrive over a valid/ready handshake and take effect only at a period boundary, so a period is never glitched mid-way.
- Sits between the counter and the gate-driver pins.

---
 rtl/pwm_deadtime_pkg.sv | 22 ++
 rtl/pwm_deadtime_gen.sv | 111 +++++++++++
 rtl/pwm_deadtime.sv | 82 ++++++++
 3 files changed

// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the dead-time PWM block: default widths and the
// dead-time FSM state encoding.
package pwm_pkg;

  localparam int BW_DEF  = 4;
  localparam int DTW_DEF = 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOW   = 3'd1;
  localparam logic [2:0] DT_LH = 3'd2;
  localparam logic [2:0] HIGH  = 3'd3;
  localparam logic [2:0] DT_HL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_LOW   = LOW,
    ST_DT_LH = DT_LH,
    ST_HIGH  = HIGH,
    ST_DT_HL = DT_HL
  } state_t;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low drive with programmable dead time between edges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | disabled, both outputs off
// LOW      | low side on (H/L = 0/1)
// DT_LH    | gap before high side turns on; aborts to LOW if raw drops
// HIGH     | high side on (H/L = 1/0)
// DT_HL    | gap before low side turns on; aborts to HIGH if raw rises
module deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_raw,
  input  logic           i_en,
  input  logic [DTW-1:0] i_dead_time,
  output logic           o_h,
  output logic           o_l
);

  state_t         r_state;
  logic [DTW-1:0] r_dt_cnt;
  logic           r_h;
  logic           r_l;

  // State, dead-time down-counter and registered drive outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_dt_cnt <= '0;
      r_h      <= 1'b0;
      r_l      <= 1'b0;
    end else if (!i_en) begin
      r_state <= ST_IDLE;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_LOW;
          r_h     <= 1'b0;
          r_l     <= 1'b1;
        end
        ST_LOW: begin
          if (i_raw) begin
            r_l <= 1'b0;
            if (i_dead_time == '0) begin
              r_state <= ST_HIGH;
              r_h     <= 1'b1;
            end else begin
              r_state  <= ST_DT_LH;
              r_dt_cnt <= i_dead_time;
              r_h      <= 1'b0;
            end
          end
        end
        ST_DT_LH: begin
          if (!i_raw) begin
            r_state <= ST_LOW;
            r_h     <= 1'b0;
            r_l     <= 1'b1;
          end else if (r_dt_cnt == DTW'(1)) begin
            r_state <= ST_HIGH;
            r_h     <= 1'b1;
            r_l     <= 1'b0;
          end else begin
            r_dt_cnt <= r_dt_cnt - DTW'(1);
          end
        end
        ST_HIGH: begin
          if (!i_raw) begin
            r_h <= 1'b0;
            if (i_dead_time == '0) begin
              r_state <= ST_LOW;
              r_l     <= 1'b1;
            end else begin
              r_state  <= ST_DT_HL;
              r_dt_cnt <= i_dead_time;
              r_l      <= 1'b0;
            end
          end
        end
        ST_DT_HL: begin
          if (i_raw) begin
            r_state <= ST_HIGH;
            r_h     <= 1'b1;
            r_l     <= 1'b0;
          end else if (r_dt_cnt == DTW'(1)) begin
            r_state <= ST_LOW;
            r_h     <= 1'b0;
            r_l     <= 1'b1;
          end else begin
            r_dt_cnt <= r_dt_cnt - DTW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_h     <= 1'b0;
          r_l     <= 1'b0;
        end
      endcase
    end
  end

  assign o_h = r_h;
  assign o_l = r_l;

endmodule

// File: rtl/pwm_deadtime.sv
// PWM comparator with a double-buffered duty value that only changes at a
// counter period boundary, driving a complementary pair through deadtime_gen.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int BW  = BW_DEF,
  parameter int DTW = DTW_DEF
) (
  input  logic           clk_i,
  input  logic           nrst_i,
  input  logic [BW-1:0]  count_i,
  input  logic           en_i,
  input  logic [BW-1:0]  duty_i,
  input  logic           dutyValid_i,
  output logic           dutyReady_o,
  input  logic [DTW-1:0] deadTime_i,
  output logic           pwmH_o,
  output logic           pwmL_o,
  output logic           periodStart_o
);

  logic [BW-1:0] r_count_prev;
  logic          r_period_start;
  logic [BW-1:0] r_pending;
  logic          r_pending_full;
  logic [BW-1:0] r_active;

  logic          w_start;
  logic          w_accept;
  logic [BW-1:0] w_eff;
  logic          w_raw;

  // A boundary is the first cycle the count sits at zero, so a held zero
  // after a counter reset does not retrigger.
  assign w_start  = (count_i == '0) && (r_count_prev != '0);
  assign w_accept = dutyValid_i && !r_pending_full;
  // The promoted duty already governs the first cycle of the new period.
  assign w_eff    = (w_start && r_pending_full) ? r_pending : r_active;
  assign w_raw    = count_i < w_eff;

  assign dutyReady_o   = !r_pending_full;
  assign periodStart_o = r_period_start;

  // Previous count for boundary detection and the registered boundary pulse.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_count_prev   <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_count_prev   <= count_i;
      r_period_start <= w_start;
    end
  end

  // Duty double buffer: accept into pending, promote to active at a boundary.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_active       <= '0;
    end else if (w_start && r_pending_full) begin
      r_active       <= r_pending;
      r_pending_full <= 1'b0;
    end else if (w_accept) begin
      r_pending      <= duty_i;
      r_pending_full <= 1'b1;
    end
  end

  deadtime_gen #(
    .DTW(DTW)
  ) u_deadtime_gen (
    .i_clk       (clk_i),
    .i_rst_n     (nrst_i),
    .i_raw       (w_raw),
    .i_en        (en_i),
    .i_dead_time (deadTime_i),
    .o_h         (pwmH_o),
    .o_l         (pwmL_o)
  );

endmodule
